// File: rtl/prot_spi_tx_pkg.sv
// Shared protocol definitions for the SPI transmitter and related protocol blocks.
package prot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } spi_tx_state_t;

    localparam int SPI_LEN16 = 16;
    localparam int SPI_LEN8  = 8;
    localparam int MIN_HALF  = 2;

endpackage

// File: rtl/prot_spi_tx_if.sv
// Start/config inputs and SPI line outputs of the SPI master transmitter.
interface prot_spi_tx_if #(
    parameter int DIV_W = 8
);
    logic             wrt;
    logic [15:0]      tx_data;
    logic             len8;
    logic             samp_rise;
    logic [DIV_W-1:0] sclk_div;
    logic             SS_n;
    logic             SCLK;
    logic             MOSI;
    logic             busy;
    logic             done;

    modport master (
        output wrt, tx_data, len8, samp_rise, sclk_div,
        input  SS_n, SCLK, MOSI, busy, done
    );

    modport slave (
        input  wrt, tx_data, len8, samp_rise, sclk_div,
        output SS_n, SCLK, MOSI, busy, done
    );
endinterface

// File: rtl/prot_spi_tx_sclk_div_cnt.sv
// Half-period counter: counts 0..half-1 while enabled and pulses tc on the last count.
module sclk_div_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] half_i,
    output logic             tc_o
);
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tc_o = en_i && (cnt_q == half_i - DIV_W'(1));

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clr_i || !en_i || tc_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/prot_spi_tx.sv
// SPI master transmitter: sends an 8- or 16-bit word MSB first with selectable sampling edge.
module prot_spi_tx
    import prot_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    prot_spi_tx_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FRONT = FRONT;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_BACK  = BACK;

    logic [1:0]       state_q, state_d;
    logic [15:0]      shift_q, shift_d;
    logic             sclk_q, sclk_d;
    logic             done_q, done_d;
    logic [4:0]       samp_cnt_q, samp_cnt_d;
    logic             len8_q;
    logic             samp_rise_q;
    logic [DIV_W-1:0] half_q;

    logic             wrt_ok;
    logic             tc;
    logic             sclk_edge;
    logic             samp_edge;
    logic             last_edge;
    logic [4:0]       n_len;
    logic [DIV_W-1:0] half_eff;

    assign wrt_ok   = bus.wrt && (state_q == S_IDLE);
    assign n_len    = len8_q ? 5'(SPI_LEN8) : 5'(SPI_LEN16);
    assign half_eff = (bus.sclk_div < DIV_W'(MIN_HALF)) ? DIV_W'(MIN_HALF) : bus.sclk_div;

    sclk_div_cnt #(.DIV_W(DIV_W)) u_div (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != S_IDLE),
        .clr_i  (state_d != state_q),
        .half_i (half_q),
        .tc_o   (tc)
    );

    // The FRONT->SHIFT transition is itself SCLK edge 1, so both states generate edges.
    assign sclk_edge = tc && ((state_q == S_FRONT) || (state_q == S_SHIFT));
    assign samp_edge = sclk_edge && ((~sclk_q) == samp_rise_q);
    assign last_edge = tc && (state_q == S_SHIFT) && !sclk_q &&
                       (samp_rise_q ? (samp_cnt_q == n_len - 5'd1) : (samp_cnt_q == n_len));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        sclk_d     = sclk_q;
        samp_cnt_d = samp_cnt_q;
        done_d     = 1'b0;

        if (sclk_edge) begin
            sclk_d = ~sclk_q;
            if (samp_edge) begin
                samp_cnt_d = samp_cnt_q + 5'd1;
            end else if ((samp_cnt_q != 5'd0) && (samp_cnt_q < n_len)) begin
                shift_d = {shift_q[14:0], 1'b0};
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.wrt) begin
                    state_d    = S_FRONT;
                    shift_d    = bus.len8 ? {bus.tx_data[7:0], 8'h00} : bus.tx_data;
                    samp_cnt_d = 5'd0;
                    sclk_d     = 1'b1;
                end
            end
            S_FRONT: begin
                if (tc) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (last_edge) state_d = S_BACK;
            end
            default: begin
                if (tc) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= 16'h0000;
            sclk_q      <= 1'b1;
            done_q      <= 1'b0;
            samp_cnt_q  <= 5'd0;
            len8_q      <= 1'b0;
            samp_rise_q <= 1'b0;
            half_q      <= DIV_W'(MIN_HALF);
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            sclk_q     <= sclk_d;
            done_q     <= done_d;
            samp_cnt_q <= samp_cnt_d;
            if (wrt_ok) begin
                len8_q      <= bus.len8;
                samp_rise_q <= bus.samp_rise;
                half_q      <= half_eff;
            end
        end
    end

    assign bus.SS_n = (state_q == S_IDLE);
    assign bus.SCLK = sclk_q;
    assign bus.MOSI = shift_q[15];
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
endmodule

// File: tb/tb_prot_spi_tx.sv
// Scoreboard bench for prot_spi_tx: a slave-side monitor captures each frame and checks it at done.
module tb_prot_spi_tx;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        logic [15:0] cap;
        int          nBits;
        int          lat;
        logic        sampRise;
        int          startCyc;
    } exp_t;

    exp_t sb[$];

    prot_spi_tx_if #(.DIV_W(8)) bus ();

    prot_spi_tx #(.DIV_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    // Slave-side monitor: counts SCLK edges and SS_n low time, shifts in MOSI on sampling edges.
    logic        prevSclk;
    logic [15:0] monCap;
    int          monRise, monFall, monLow;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prevSclk = 1'b1;
            monCap   = 16'h0;
            monRise  = 0;
            monFall  = 0;
            monLow   = 0;
        end else begin
            if (bus.SS_n == 1'b0) monLow++;
            if ((bus.SCLK !== prevSclk) && (bus.SS_n == 1'b0)) begin
                if (bus.SCLK) monRise++;
                else          monFall++;
                if ((sb.size() > 0) && (bus.SCLK == sb[0].sampRise))
                    monCap = {monCap[14:0], bus.MOSI};
            end
            prevSclk = bus.SCLK;
            if (bus.busy && bus.done) checkOutput("busy_and_done", 1, 0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("capture", int'(e.nBits == 8 ? {8'h00, monCap[7:0]} : monCap), int'(e.cap));
                    checkOutput("sclk_rises", monRise, e.nBits);
                    checkOutput("sclk_falls", monFall, e.nBits);
                    checkOutput("ssn_low_cycles", monLow, e.lat - 1);
                    checkOutput("done_latency", cyc - e.startCyc, e.lat);
                end
                monCap  = 16'h0;
                monRise = 0;
                monFall = 0;
                monLow  = 0;
            end
        end
    end

    // Drives one wrt strobe from the current (non-edge) time and records the expectation.
    task automatic applyStimulus(input logic [15:0] data, input logic l8, input logic sr,
                                 input logic [7:0] div, input logic [15:0] expCap, input int lat);
        exp_t e;
        e.cap      = expCap;
        e.nBits    = l8 ? 8 : 16;
        e.lat      = lat;
        e.sampRise = sr;
        e.startCyc = cyc;
        sb.push_back(e);
        bus.tx_data   = data;
        bus.len8      = l8;
        bus.samp_rise = sr;
        bus.sclk_div  = div;
        bus.wrt       = 1'b1;
        @(posedge clk);
        #1 bus.wrt = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        cyc   = 0;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.wrt       = 1'b0;
        bus.tx_data   = 16'h0;
        bus.len8      = 1'b0;
        bus.samp_rise = 1'b0;
        bus.sclk_div  = 8'd4;
        repeat (3) @(negedge clk);
        checkOutput("reset_SS_n", int'(bus.SS_n), 1);
        checkOutput("reset_SCLK", int'(bus.SCLK), 1);
        checkOutput("reset_MOSI", int'(bus.MOSI), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_done", int'(bus.done), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        applyStimulus(16'h5555, 1'b0, 1'b1, 8'd4, 16'h5555, 133);
        waitDone(300);
        repeat (3) @(negedge clk);
        applyStimulus(16'h0444, 1'b0, 1'b0, 8'd4, 16'h0444, 133);
        waitDone(300);
        repeat (3) @(negedge clk);
        applyStimulus(16'h3328, 1'b1, 1'b1, 8'd4, 16'h0028, 69);
        waitDone(300);
        repeat (3) @(negedge clk);
        applyStimulus(16'h3333, 1'b1, 1'b0, 8'd3, 16'h0033, 52);
        waitDone(300);
        repeat (3) @(negedge clk);
        applyStimulus(16'hA5C3, 1'b0, 1'b1, 8'd0, 16'hA5C3, 67);
        waitDone(300);
        repeat (3) @(negedge clk);
        applyStimulus(16'hFF81, 1'b1, 1'b0, 8'd1, 16'h0081, 35);
        waitDone(300);
        repeat (3) @(negedge clk);

        $display("[TB] frame with mid-frame wrt pulses and input changes");
        applyStimulus(16'hBEEF, 1'b0, 1'b1, 8'd4, 16'hBEEF, 133);
        repeat (8) @(posedge clk);
        #1;
        bus.tx_data = 16'h1234; bus.len8 = 1'b1; bus.samp_rise = 1'b0; bus.sclk_div = 8'd2;
        bus.wrt = 1'b1;
        @(posedge clk);
        #1 bus.wrt = 1'b0;
        repeat (39) @(posedge clk);
        #1 bus.wrt = 1'b1;
        @(posedge clk);
        #1 bus.wrt = 1'b0;
        waitDone(300);
        checkOutput("done_cycle_SS_n", int'(bus.SS_n), 1);
        applyStimulus(16'h7E3C, 1'b1, 1'b1, 8'd2, 16'h003C, 35);
        @(negedge clk);
        checkOutput("b2b_SS_n_low", int'(bus.SS_n), 0);
        waitDone(300);
        repeat (30) @(negedge clk);
        checkOutput("idle_busy", int'(bus.busy), 0);

        $display("[TB] reset asserted mid-frame");
        applyStimulus(16'hF8A5, 1'b0, 1'b1, 8'd4, 16'hF8A5, 133);
        repeat (39) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("abort_SS_n", int'(bus.SS_n), 1);
        checkOutput("abort_SCLK", int'(bus.SCLK), 1);
        checkOutput("abort_MOSI", int'(bus.MOSI), 0);
        checkOutput("abort_busy", int'(bus.busy), 0);
        checkOutput("abort_done", int'(bus.done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        applyStimulus(16'h96E1, 1'b0, 1'b0, 8'd5, 16'h96E1, 166);
        waitDone(400);
        repeat (5) @(negedge clk);

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
